// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Two-cycle fetch/execute sequencer for the 4-bit accumulator datapath.
// Fetches 8-bit instructions from an external combinational ROM and drives
// the datapath control lines. It latches the ALU carry/zero flags and
// executes conditional jumps.
//
// Ports
//   Clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   start    in   begin program at address 0 (honoured in IDLE/HALT only)
//   instr    in   [7:0] ROM data at pc; [7:4] opcode, [3:0] operand
//   carry    in   ALU carry/borrow
//   exit     in   ALU zero
//   pc       out  [3:0] ROM address
//   operand  out  [3:0] value driven onto the datapath input bus
//   command  out  [2:0] ALU operation select
//   En1      out  input-bus tri-state enable
//   En       out  accumulator load enable
//   En2      out  output tri-state enable
//   c_flag   out  latched carry
//   z_flag   out  latched zero
//   busy     out  high in FETCH/EXEC
//   done     out  high in HALT
module alu_seq_ctrl (
  input  logic       Clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       carry,
  input  logic       exit,
  output logic [3:0] pc,
  output logic [3:0] operand,
  output logic [2:0] command,
  output logic       En1,
  output logic       En,
  output logic       En2,
  output logic       c_flag,
  output logic       z_flag,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LIT  = 4'h1,
    OP_CMP  = 4'h2,
    OP_ADD  = 4'h3,
    OP_NAND = 4'h4,
    OP_OUT  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JC   = 4'h7,
    OP_JZ   = 4'h8,
    OP_HALT = 4'hF
  } op_e;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       c_q, c_d;
  logic       z_q, z_d;

  // State and architectural registers
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    c_d     = c_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          c_d     = 1'b0;
          z_d     = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = instr;
        pc_d    = pc_q + 4'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        // Flags are captured from the ALU at the edge ending EXEC; jumps
        // test the flag values registered before this instruction.
        case (ir_q[7:4])
          OP_CMP, OP_ADD: begin
            c_d = carry;
            z_d = exit;
          end
          OP_JMP:  pc_d = ir_q[3:0];
          OP_JC:   if (c_q) pc_d = ir_q[3:0];
          OP_JZ:   if (z_q) pc_d = ir_q[3:0];
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath controls decoded from registered state and ir only
  always_comb begin
    operand = '0;
    command = 3'b000;
    En1     = 1'b0;
    En      = 1'b0;
    En2     = 1'b0;
    busy    = (state_q == S_FETCH) || (state_q == S_EXEC);
    done    = (state_q == S_HALT);
    if (state_q == S_EXEC) begin
      operand = ir_q[3:0];
      case (ir_q[7:4])
        OP_LIT: begin
          command = 3'b010;
          En1     = 1'b1;
          En      = 1'b1;
        end
        OP_CMP: begin
          command = 3'b001;
          En1     = 1'b1;
        end
        OP_ADD: begin
          command = 3'b011;
          En1     = 1'b1;
          En      = 1'b1;
        end
        OP_NAND: begin
          command = 3'b100;
          En1     = 1'b1;
          En      = 1'b1;
        end
        OP_OUT:  En2 = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc     = pc_q;
  assign c_flag = c_q;
  assign z_flag = z_q;

endmodule
